// File: rtl/framebuffer_bank_ctrl_pkg.sv
// Shared definitions for the framebuffer double-buffer bank controller:
// swap FSM encoding and the bank-bit positions that multimem sizing depends on.
package framebuffer_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DONE    = 2'd2
    } swap_state_t;

    // Bank bit sits directly above the native address on each side.
    localparam int unsigned WR_ADDR_BITS = 12;
    localparam int unsigned RD_ADDR_BITS = 11;
    localparam int unsigned WR_BANK_BIT  = WR_ADDR_BITS;
    localparam int unsigned RD_BANK_BIT  = RD_ADDR_BITS;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/framebuffer_bank_ctrl_watchdog.sv
// Swap watchdog: counts cycles while enabled and pulses expire on the
// cycle the count reaches TICKS-1, so a forced swap lands TICKS cycles in.
module bank_swap_watchdog #(
    parameter int unsigned          W     = 20,
    parameter logic [W-1:0]         TICKS = 20'd727273
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam logic [W-1:0] LAST = W'(TICKS - 1'b1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)         cnt <= '0;
        else if (clear)    cnt <= '0;
        else if (count_en) cnt <= cnt + 1'b1;
    end

    assign expire = count_en & (cnt == LAST);

endmodule

// File: rtl/framebuffer_bank_ctrl.sv
// Double-buffer bank controller: writes go to the back bank, fetch reads the
// front bank, and swaps commit only on a frame edge or watchdog expiry.
module framebuffer_bank_ctrl
    import framebuffer_bank_ctrl_pkg::*;
#(
    parameter int unsigned              ADDR_A_WIDTH  = WR_ADDR_BITS,
    parameter int unsigned              ADDR_B_WIDTH  = RD_ADDR_BITS,
    parameter int unsigned              TIMEOUT_WIDTH = 20,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 20'd727273
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    dbuf_en,
    input  logic                    swap_req,
    input  logic                    frame_sync,
    input  logic [ADDR_A_WIDTH-1:0] wr_addr_in,
    input  logic                    wr_en_in,
    input  logic [ADDR_B_WIDTH-1:0] rd_addr_in,
    output logic [ADDR_A_WIDTH:0]   wr_addr_out,
    output logic                    wr_en_out,
    output logic [ADDR_B_WIDTH:0]   rd_addr_out,
    output logic                    front_bank,
    output logic                    wr_busy,
    output logic                    swap_done,
    output logic                    swap_timeout,
    output logic [7:0]              frame_count,
    output logic [7:0]              dropped_writes
);

    swap_state_t state, state_nx;
    logic        front_nx;
    logic        to_flag, to_flag_nx;
    logic        fs_q, fs_edge;
    logic        wd_clear, wd_expire;

    // fs_q resets high so a frame_sync held high through reset is not an edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) fs_q <= 1'b1;
        else       fs_q <= frame_sync;
    end

    assign fs_edge = frame_sync & ~fs_q;

    bank_swap_watchdog #(
        .W     (TIMEOUT_WIDTH),
        .TICKS (TIMEOUT_TICKS)
    ) u_wdog (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (state == ST_PENDING),
        .expire   (wd_expire)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            front_bank <= 1'b0;
            to_flag    <= 1'b0;
        end else begin
            state      <= state_nx;
            front_bank <= front_nx;
            to_flag    <= to_flag_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        front_nx   = front_bank;
        to_flag_nx = to_flag;
        wd_clear   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // An edge coincident with the request is not consumed here.
                if (swap_req) begin
                    state_nx = dbuf_en ? ST_PENDING : ST_DONE;
                    wd_clear = dbuf_en;
                end
            end
            ST_PENDING: begin
                if (fs_edge) begin
                    front_nx = ~front_bank;
                    state_nx = ST_DONE;
                end else if (wd_expire) begin
                    front_nx   = ~front_bank;
                    to_flag_nx = 1'b1;
                    state_nx   = ST_DONE;
                end
            end
            ST_DONE: begin
                to_flag_nx = 1'b0;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Single buffering pins both sides to bank 0 and aborts any pending swap.
        if (!dbuf_en) begin
            front_nx   = 1'b0;
            to_flag_nx = 1'b0;
            if (state != ST_IDLE) state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            frame_count    <= 8'd0;
            dropped_writes <= 8'd0;
        end else begin
            if (fs_edge)             frame_count    <= frame_count + 8'd1;
            if (wr_en_in && wr_busy) dropped_writes <= sat_inc8(dropped_writes);
        end
    end

    assign wr_busy      = (state != ST_IDLE);
    assign wr_en_out    = wr_en_in & ~wr_busy;
    assign swap_done    = (state == ST_DONE);
    assign swap_timeout = (state == ST_DONE) & to_flag;
    assign wr_addr_out  = {dbuf_en & ~front_bank, wr_addr_in};
    assign rd_addr_out  = {dbuf_en & front_bank, rd_addr_in};

endmodule

// File: tb/tb_framebuffer_bank_ctrl.sv
// Scoreboard bench for framebuffer_bank_ctrl: swap events are queued by the
// stimulus and retired by a monitor watching swap_done.
module tb_framebuffer_bank_ctrl;

    localparam int unsigned AW = 12;
    localparam int unsigned BW = 11;
    localparam int unsigned TW = 20;
    localparam int          TO = 400;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          dbuf_en, swap_req, frame_sync, wr_en_in;
    logic [AW-1:0] wr_addr_in;
    logic [BW-1:0] rd_addr_in;
    logic [AW:0]   wr_addr_out;
    logic [BW:0]   rd_addr_out;
    logic          wr_en_out, front_bank, wr_busy, swap_done, swap_timeout;
    logic [7:0]    frame_count, dropped_writes;

    framebuffer_bank_ctrl #(
        .ADDR_A_WIDTH  (AW),
        .ADDR_B_WIDTH  (BW),
        .TIMEOUT_WIDTH (TW),
        .TIMEOUT_TICKS (20'd400)
    ) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .dbuf_en        (dbuf_en),
        .swap_req       (swap_req),
        .frame_sync     (frame_sync),
        .wr_addr_in     (wr_addr_in),
        .wr_en_in       (wr_en_in),
        .rd_addr_in     (rd_addr_in),
        .wr_addr_out    (wr_addr_out),
        .wr_en_out      (wr_en_out),
        .rd_addr_out    (rd_addr_out),
        .front_bank     (front_bank),
        .wr_busy        (wr_busy),
        .swap_done      (swap_done),
        .swap_timeout   (swap_timeout),
        .frame_count    (frame_count),
        .dropped_writes (dropped_writes)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int   cyc;
        logic front;
        logic timeout;
    } swap_exp_t;

    swap_exp_t exp_q[$];
    swap_exp_t mon_e;
    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    int        exp_fc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every swap_done pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (swap_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL swap_done_unexpected: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.front != front_bank || mon_e.timeout != swap_timeout) begin
                    errors++;
                    $display("FAIL swap_event: got cyc=%0d front=%0b timeout=%0b, required cyc=%0d front=%0b timeout=%0b",
                             cyc, front_bank, swap_timeout, mon_e.cyc, mon_e.front, mon_e.timeout);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_swap(input int c, input logic f, input logic t);
        swap_exp_t e;
        e.cyc = c; e.front = f; e.timeout = t;
        exp_q.push_back(e);
    endtask

    int n, m, p, bad;

    initial begin
        reset = 1'b1; dbuf_en = 1'b1; swap_req = 1'b0; frame_sync = 1'b1;
        wr_en_in = 1'b0; wr_addr_in = 12'h5a5; rd_addr_in = 11'h123;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state, frame_sync held high
        wr_en_in = 1'b1;
        repeat (5) tick();
        @(negedge clk_in);
        check("rst_frame_count", frame_count, 0);
        check("rst_front_bank", front_bank, 0);
        check("rst_wr_bank_bit", wr_addr_out[12], 1);
        check("rst_rd_bank_bit", rd_addr_out[11], 0);
        check("rst_wr_busy", wr_busy, 0);
        check("rst_wr_en_out", wr_en_out, 1);
        check("rst_dropped", dropped_writes, 0);
        check("rst_wr_addr_low", wr_addr_out[11:0], 'h5a5);
        wr_en_in = 1'b0; frame_sync = 1'b0;
        tick(); tick();

        // Normal swap on a frame edge 10 cycles after the request
        swap_req = 1'b1; n = cyc;
        tick();
        swap_req = 1'b0;
        @(negedge clk_in);
        check("req_wr_busy", wr_busy, 1);
        check("req_front_hold", front_bank, 0);
        repeat (9) tick();
        frame_sync = 1'b1; m = cyc; exp_fc++;
        push_swap(m + 1, 1'b1, 1'b0);
        tick();
        @(negedge clk_in);
        check("edge_front_bank", front_bank, 1);
        check("edge_wr_bank_bit", wr_addr_out[12], 0);
        check("edge_rd_bank_bit", rd_addr_out[11], 1);
        tick();
        @(negedge clk_in);
        check("edge_busy_release", wr_busy, 0);
        check("edge_frame_count", frame_count, exp_fc);
        frame_sync = 1'b0;
        tick();

        // Forced swap with 300 blocked writes while pending
        swap_req = 1'b1; n = cyc;
        push_swap(n + 1 + TO, 1'b0, 1'b1);
        tick();
        swap_req = 1'b0; wr_en_in = 1'b1; bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (wr_en_out !== 1'b0) bad++;
            tick();
        end
        wr_en_in = 1'b0;
        check("pend_wr_en_out_blocked", bad, 0);
        check("pend_dropped_sat", dropped_writes, 255);
        check("pend_front_hold", front_bank, 1);
        while (cyc < n + 2 + TO) tick();
        @(negedge clk_in);
        check("to_front_bank", front_bank, 0);
        check("to_busy_release", wr_busy, 0);

        // dbuf_en dropped mid-pending aborts without swap_done
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        repeat (5) tick();
        dbuf_en = 1'b0;
        tick();
        @(negedge clk_in);
        check("abort_busy", wr_busy, 0);
        check("abort_front", front_bank, 0);
        frame_sync = 1'b1; exp_fc++;
        tick();
        frame_sync = 1'b0;
        tick();
        swap_req = 1'b1; p = cyc;
        push_swap(p + 1, 1'b0, 1'b0);
        tick();
        swap_req = 1'b0;
        @(negedge clk_in);
        check("sb_front", front_bank, 0);
        check("sb_wr_bank_bit", wr_addr_out[12], 0);
        tick(); tick();

        // Request coincident with a frame edge waits for the next edge
        dbuf_en = 1'b1;
        tick();
        swap_req = 1'b1; frame_sync = 1'b1; exp_fc++;
        tick();
        swap_req = 1'b0;
        @(negedge clk_in);
        check("coinc_no_swap", front_bank, 0);
        check("coinc_busy", wr_busy, 1);
        repeat (3) tick();
        frame_sync = 1'b0;
        repeat (3) tick();
        frame_sync = 1'b1; m = cyc; exp_fc++;
        push_swap(m + 1, 1'b1, 1'b0);
        tick();
        @(negedge clk_in);
        check("coinc_front", front_bank, 1);
        check("coinc_frame_count", frame_count, exp_fc);
        frame_sync = 1'b0;
        tick(); tick();

        // Dropping dbuf_en with front bank 1 returns both sides to bank 0
        dbuf_en = 1'b0;
        tick();
        @(negedge clk_in);
        check("sb_force_front0", front_bank, 0);
        check("sb_rd_bank_bit", rd_addr_out[11], 0);

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
